multi_exchange_packet_parser: RTL and testbench
===============================================

Name: multi_exchange_packet_parser

Overview:
Byte-level framer/parser between the UART receiver and the arbitrage compute core.
- Generalises the fixed two-exchange, 16-bit price packet to N_EXCH exchanges with PRICE_BYTES bytes per price.
- Adds an optional XOR checksum byte, an inter-byte timeout and error reporting.
- Outputs a double-buffered price vector that changes only when a complete packet validates.

Parameters:
N_EXCH, 2, number of exchange prices per packet (1..8)
PRICE_BYTES, 2, bytes per price, big-endian on the wire (1..4)
HEADER, 8'hAA, packet start byte
FOOTER, 8'h55, packet end byte
CHECKSUM_EN, 1, 1 = one XOR checksum byte between the last price byte and the footer
TIMEOUT_CYCLES, 104167, idle clocks allowed between accepted bytes inside a packet (about 2 byte times at 9600 baud with a 50 MHz clock)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
rx_data  input  8  received byte from the UART receiver
rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle
prices  output  N_EXCH*PRICE_BYTES*8  validated prices; price k occupies bits [(k+1)*PW-1 : k*PW], where PW = PRICE_BYTES*8 and k = 0 is the first price on the wire
packet_valid  output  1  one-cycle pulse; prices just updated
pkt_error  output  1  one-cycle pulse; packet discarded
err_code  output  2  1 = bad footer, 2 = checksum mismatch, 3 = timeout; held until the next pkt_error
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - state IDLE; prices = 0; packet_valid = 0; pkt_error = 0; err_code = 0; busy = 0.
  - Internal shadow buffer, byte counter, checksum accumulator and timeout counter are all cleared.
  - rx_valid is ignored in any cycle where rst = 1.
- State machine. Bytes are consumed only on rx_valid.
  - IDLE: byte == HEADER -> PRICE, with byte_cnt = 0 and chk = 0. Any other byte is discarded silently, with no error.
  - PRICE: the byte is written to shadow[price byte_cnt / PRICE_BYTES]. The first byte of each price is its MSB. chk ^= byte and byte_cnt increments. When byte_cnt reaches N_EXCH*PRICE_BYTES-1 on the accepted byte, go to CHECK if CHECKSUM_EN = 1, otherwise to FOOTER.
  - Any byte value, including HEADER or FOOTER, is treated as price data in PRICE and CHECK; there is no in-band escaping.
  - CHECK: byte == chk -> FOOTER. Otherwise pkt_error with err_code = 2, then IDLE.
  - FOOTER, byte == FOOTER:
    - prices <= shadow and packet_valid = 1, both registered in the cycle after the footer strobe. Latency from the footer rx_valid to packet_valid is 1 clk.
    - Then IDLE.
  - FOOTER, byte != FOOTER: pkt_error with err_code = 1.
    - If that byte == HEADER, go directly to PRICE with byte_cnt and chk cleared (resync).
    - Otherwise go to IDLE.
- Timeout:
  - Counter clears on every accepted byte and while in IDLE.
  - Counter increments every clk in the other states when rx_valid = 0.
  - When it reaches TIMEOUT_CYCLES-1: pkt_error with err_code = 3, then IDLE, and the shadow buffer is discarded.
  - If rx_valid arrives in the same cycle as the terminal count, the byte wins: it is processed and no timeout occurs.
- prices never shows partial data: it holds its old value through errors, timeouts and mid-packet activity.
- packet_valid and pkt_error are mutually exclusive and never high for more than 1 clk per event.
- Back-to-back packets:
  - A HEADER arriving in IDLE the cycle right after the footer is accepted normally.
  - The minimum spacing between rx_valid strobes is 1 clk; the block must sustain rx_valid in every cycle.
- Reset mid-packet: rst at any state returns to IDLE with all reset values, including prices = 0.
  - A partial packet resumed after reset is ignored until the next HEADER.
- The counters are sized with $clog2 of N_EXCH*PRICE_BYTES and TIMEOUT_CYCLES. There is no arithmetic on the prices themselves.

Test Plan:
- Defaults: send AA 10 AE 10 8B 25 55 (prices 4270 and 4235, checksum 0x25) -> packet_valid pulses 1 clk after the 0x55 strobe; prices = 32'h108B10AE; pkt_error stays 0.
- Same packet with checksum 0x26 -> pkt_error with err_code = 2; no packet_valid; prices unchanged (0 after reset).
- Packet with footer 0xAA, followed by 10 AE 10 8B 25 55 -> pkt_error with err_code = 1, then resync; packet_valid follows with prices = 32'h108B10AE.
- Send AA 10 AE, then no byte for 104167 clks -> pkt_error with err_code = 3 at terminal count; busy falls. The next full packet validates normally.
- Noise before the header (3C 55 00), then a valid packet, then two valid packets with rx_valid on consecutive cycles -> noise is ignored with no error, and three packet_valid pulses occur.
- N_EXCH = 3, PRICE_BYTES = 3, CHECKSUM_EN = 0: send AA 01 02 03 04 05 06 07 08 09 55 -> prices = 72'h070809_040506_010203. Also assert rst after byte 4 of a second packet -> all outputs return to reset values.

Source files
------------

// File: rtl/multi_exchange_packet_parser.sv
// Byte-level framer for HEADER, N_EXCH big-endian prices, optional XOR checksum, FOOTER.
// Prices are staged in a shadow buffer and published only when a packet fully validates.
module multi_exchange_packet_parser #(
    parameter int unsigned N_EXCH         = 2,
    parameter int unsigned PRICE_BYTES    = 2,
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter logic [7:0]  FOOTER         = 8'h55,
    parameter bit          CHECKSUM_EN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 104167
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic [N_EXCH*PRICE_BYTES*8-1:0] prices,
    output logic                            packet_valid,
    output logic                            pkt_error,
    output logic [1:0]                      err_code,
    output logic                            busy
);

    localparam int unsigned NB    = N_EXCH * PRICE_BYTES;
    localparam int unsigned PW    = PRICE_BYTES * 8;
    localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRICE  = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_FOOTER = 2'd3;

    logic [1:0]        state;
    logic [NB*8-1:0]   shadow;
    logic [CNT_W-1:0]  byte_cnt;
    logic [7:0]        chk;
    logic [TO_W-1:0]   to_cnt;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            shadow       <= '0;
            byte_cnt     <= '0;
            chk          <= '0;
            to_cnt       <= '0;
            prices       <= '0;
            packet_valid <= 1'b0;
            pkt_error    <= 1'b0;
            err_code     <= 2'd0;
        end else begin
            packet_valid <= 1'b0;
            pkt_error    <= 1'b0;

            if (state == S_IDLE) begin
                to_cnt <= '0;
                if (rx_valid && rx_data == HEADER) begin
                    state    <= S_PRICE;
                    byte_cnt <= '0;
                    chk      <= '0;
                end
            end else if (!rx_valid) begin
                // A byte arriving on the terminal count bypasses this branch, so the byte wins.
                if (to_cnt == TO_LAST) begin
                    state     <= S_IDLE;
                    pkt_error <= 1'b1;
                    err_code  <= 2'd3;
                    shadow    <= '0;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
                case (state)
                    S_PRICE: begin
                        // Price k sits at the low end of the vector; its first wire byte is the MSB.
                        for (int unsigned i = 0; i < NB; i++) begin
                            if (byte_cnt == CNT_W'(i))
                                shadow[(i / PRICE_BYTES) * PW + (PRICE_BYTES - 1 - (i % PRICE_BYTES)) * 8 +: 8] <= rx_data;
                        end
                        chk <= chk ^ rx_data;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= CHECKSUM_EN ? S_CHECK : S_FOOTER;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (rx_data == chk) begin
                            state <= S_FOOTER;
                        end else begin
                            state     <= S_IDLE;
                            pkt_error <= 1'b1;
                            err_code  <= 2'd2;
                        end
                    end
                    S_FOOTER: begin
                        if (rx_data == FOOTER) begin
                            prices       <= shadow;
                            packet_valid <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            pkt_error <= 1'b1;
                            err_code  <= 2'd1;
                            if (rx_data == HEADER) begin
                                state    <= S_PRICE;
                                byte_cnt <= '0;
                                chk      <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_exchange_packet_parser.sv
// Directed bench: default 2x16-bit config with a short timeout, plus a 3x24-bit no-checksum config.
module tb_multi_exchange_packet_parser;

    localparam int unsigned T = 200;

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic [7:0]  rx_data, rx3_data;
    logic        rx_valid, rx3_valid;
    logic [31:0] prices;
    logic [71:0] prices3;
    logic        packet_valid, pkt_error, busy;
    logic        packet_valid3, pkt_error3, busy3;
    logic [1:0]  err_code, err_code3;

    int checks = 0;
    int passes = 0;
    int pv_cnt = 0, err_cnt = 0, pv3_cnt = 0, err3_cnt = 0, excl_viol = 0;

    always #5 clk = ~clk;

    multi_exchange_packet_parser #(
        .N_EXCH(2), .PRICE_BYTES(2), .HEADER(8'hAA), .FOOTER(8'h55),
        .CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .prices(prices), .packet_valid(packet_valid), .pkt_error(pkt_error),
        .err_code(err_code), .busy(busy)
    );

    multi_exchange_packet_parser #(
        .N_EXCH(3), .PRICE_BYTES(3), .CHECKSUM_EN(1'b0)
    ) dut3 (
        .clk(clk), .rst(rst3), .rx_data(rx3_data), .rx_valid(rx3_valid),
        .prices(prices3), .packet_valid(packet_valid3), .pkt_error(pkt_error3),
        .err_code(err_code3), .busy(busy3)
    );

    always begin
        @(posedge clk);
        #1;
        if (packet_valid === 1'b1) pv_cnt++;
        if (pkt_error === 1'b1) err_cnt++;
        if (packet_valid3 === 1'b1) pv3_cnt++;
        if (pkt_error3 === 1'b1) err3_cnt++;
        if ((packet_valid && pkt_error) || (packet_valid3 && pkt_error3)) excl_viol++;
    end

    // Present a byte for one posedge; consecutive calls give back-to-back strobes.
    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] b);
        rx3_data = b; rx3_valid = 1'b1;
        @(negedge clk);
        rx3_valid = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (prices !== 32'h0) $display("FAIL reset_prices got=%h exp=0", prices); else passes++;
        checks++; if (packet_valid !== 1'b0 || pkt_error !== 1'b0)
            $display("FAIL reset_pulses got pv=%b err=%b exp 0/0", packet_valid, pkt_error); else passes++;
        checks++; if (err_code !== 2'd0) $display("FAIL reset_err_code got=%0d exp=0", err_code); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    endtask

    task automatic test_valid_packet;
        int e0;
        e0 = err_cnt;
        send(8'hAA); send(8'h10); send(8'hAE);
        checks++; if (busy !== 1'b1) $display("FAIL busy_mid got=%b exp=1", busy); else passes++;
        send(8'h10); send(8'h8B); send(8'h25);
        checks++; if (packet_valid !== 1'b0) $display("FAIL pv_early got=%b exp=0", packet_valid); else passes++;
        send(8'h55);
        checks++; if (packet_valid !== 1'b1) $display("FAIL pv_latency got=%b exp=1", packet_valid); else passes++;
        checks++; if (prices !== 32'h108B10AE) $display("FAIL valid_prices got=%h exp=108b10ae", prices); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL busy_after got=%b exp=0", busy); else passes++;
        @(negedge clk);
        checks++; if (packet_valid !== 1'b0) $display("FAIL pv_width got=%b exp=0", packet_valid); else passes++;
        checks++; if (err_cnt !== e0) $display("FAIL valid_no_err got=%0d exp=%0d", err_cnt, e0); else passes++;
    endtask

    task automatic test_bad_checksum;
        int p0, e0;
        do_reset();
        p0 = pv_cnt;
        send(8'hAA); send(8'h10); send(8'hAE); send(8'h10); send(8'h8B); send(8'h26);
        checks++; if (pkt_error !== 1'b1 || err_code !== 2'd2)
            $display("FAIL chk_err got err=%b code=%0d exp 1/2", pkt_error, err_code); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL chk_busy got=%b exp=0", busy); else passes++;
        e0 = err_cnt;
        send(8'h55);
        @(negedge clk);
        checks++; if (err_cnt !== e0) $display("FAIL chk_idle_noise got=%0d exp=%0d", err_cnt, e0); else passes++;
        checks++; if (pv_cnt !== p0) $display("FAIL chk_no_pv got=%0d exp=%0d", pv_cnt, p0); else passes++;
        checks++; if (prices !== 32'h0) $display("FAIL chk_prices got=%h exp=0", prices); else passes++;
    endtask

    task automatic test_bad_footer;
        send(8'hAA); send(8'h10); send(8'hAE); send(8'h10); send(8'h8B); send(8'h25); send(8'hAA);
        checks++; if (pkt_error !== 1'b1 || err_code !== 2'd1)
            $display("FAIL footer_err got err=%b code=%0d exp 1/1", pkt_error, err_code); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL resync_busy got=%b exp=1", busy); else passes++;
        send(8'h10); send(8'hAE); send(8'h10); send(8'h8B); send(8'h25); send(8'h55);
        checks++; if (packet_valid !== 1'b1 || prices !== 32'h108B10AE)
            $display("FAIL resync_pkt got pv=%b prices=%h exp 1/108b10ae", packet_valid, prices); else passes++;
        checks++; if (err_code !== 2'd1) $display("FAIL err_code_hold got=%0d exp=1", err_code); else passes++;
    endtask

    task automatic test_timeout;
        int n, e0;
        send(8'hAA); send(8'h10); send(8'hAE);
        n = 0;
        while (pkt_error !== 1'b1 && n < int'(T) + 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== int'(T)) $display("FAIL timeout_cycles got=%0d exp=%0d", n, T); else passes++;
        checks++; if (err_code !== 2'd3 || busy !== 1'b0)
            $display("FAIL timeout_state got code=%0d busy=%b exp 3/0", err_code, busy); else passes++;
        checks++; if (prices !== 32'h108B10AE) $display("FAIL timeout_prices got=%h exp=108b10ae", prices); else passes++;
        // Byte lands exactly on the terminal count and must win.
        e0 = err_cnt;
        send(8'hAA); send(8'h12);
        repeat (T - 1) @(negedge clk);
        send(8'h34); send(8'h56); send(8'h78); send(8'h08); send(8'h55);
        checks++; if (packet_valid !== 1'b1 || prices !== 32'h56781234)
            $display("FAIL edge_byte_wins got pv=%b prices=%h exp 1/56781234", packet_valid, prices); else passes++;
        checks++; if (err_cnt !== e0) $display("FAIL edge_no_timeout got=%0d exp=%0d", err_cnt, e0); else passes++;
    endtask

    task automatic test_back_to_back;
        int p0, e0;
        p0 = pv_cnt; e0 = err_cnt;
        send(8'h3C); send(8'h55); send(8'h00);
        send(8'hAA); send(8'h10); send(8'hAE); send(8'h10); send(8'h8B); send(8'h25); send(8'h55);
        send(8'hAA); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h08); send(8'h55);
        send(8'hAA); send(8'h00); send(8'h01); send(8'h00); send(8'h02); send(8'h03); send(8'h55);
        @(negedge clk);
        checks++; if (pv_cnt - p0 !== 3) $display("FAIL b2b_pv_count got=%0d exp=3", pv_cnt - p0); else passes++;
        checks++; if (err_cnt !== e0) $display("FAIL b2b_no_err got=%0d exp=%0d", err_cnt, e0); else passes++;
        checks++; if (prices !== 32'h00020001) $display("FAIL b2b_prices got=%h exp=00020001", prices); else passes++;
    endtask

    task automatic test_wide;
        int p0, e0;
        @(negedge clk);
        rst3 = 1'b1; rx3_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        send3(8'hAA);
        for (int i = 1; i <= 9; i++) send3(8'(i));
        send3(8'h55);
        checks++; if (packet_valid3 !== 1'b1 || prices3 !== 72'h070809_040506_010203)
            $display("FAIL wide_prices got pv=%b prices=%h exp 1/070809040506010203", packet_valid3, prices3); else passes++;
        send3(8'hAA); send3(8'h11); send3(8'h22); send3(8'h33);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        checks++; if (prices3 !== 72'h0 || busy3 !== 1'b0 || packet_valid3 !== 1'b0 || pkt_error3 !== 1'b0 || err_code3 !== 2'd0)
            $display("FAIL wide_midreset got prices=%h busy=%b pv=%b err=%b code=%0d exp all 0",
                     prices3, busy3, packet_valid3, pkt_error3, err_code3); else passes++;
        p0 = pv3_cnt; e0 = err3_cnt;
        send3(8'h44); send3(8'h55); send3(8'h66); send3(8'h77); send3(8'h88); send3(8'h99); send3(8'h55);
        @(negedge clk);
        checks++; if (pv3_cnt !== p0 || err3_cnt !== e0 || busy3 !== 1'b0)
            $display("FAIL wide_resume_ignored got pv=%0d err=%0d busy=%b exp %0d/%0d/0",
                     pv3_cnt, err3_cnt, busy3, p0, e0); else passes++;
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        rx_data = 8'h00; rx_valid = 1'b0; rx3_data = 8'h00; rx3_valid = 1'b0;
        test_reset();
        test_valid_packet();
        test_bad_checksum();
        test_bad_footer();
        test_timeout();
        test_back_to_back();
        test_wide();
        checks++; if (excl_viol !== 0) $display("FAIL pv_err_exclusive got=%0d exp=0", excl_viol); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
